mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin between ports, 0 = fixed priority with data port winning.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch-port read request, held until if_gnt.
REQ-005 if_addr  input  8  fetch word address.
REQ-006 if_gnt  output  1  one-cycle grant, fetch port.
REQ-007 if_rvalid  output  1  one-cycle pulse, if_rdata valid.
REQ-008 if_rdata  output  16  fetch read data, held between pulses.
REQ-009 d_req  input  1  data-port request, held until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load; sampled with d_req.
REQ-011 d_addr  input  8  data word address.
REQ-012 d_wdata  input  16  store data.
REQ-013 d_gnt  output  1  one-cycle grant, data port.
REQ-014 d_done  output  1  one-cycle pulse on load or store completion.
REQ-015 d_rdata  output  16  load data, held between pulses; unchanged by stores.
REQ-016 MemRead  output  1  memory read strobe.
REQ-017 MemWrite  output  1  memory write strobe.
REQ-018 Memaddr  output  8  memory address.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  memory synchronous read data, valid the cycle after MemRead.
REQ-021 busy  output  1  high whenever state is not IDLE.

Function
REQ-022 FSM states: IDLE, ISSUE, RESP; transitions only on rising clk.
REQ-023 IDLE: any req high -> ISSUE, winner's addr/we/wdata latched, winner's gnt high during ISSUE; no req -> stay IDLE.
REQ-024 ISSUE: Memaddr/mem_wdata from latched values; MemRead = fetch or load, MemWrite = store; never both high; -> RESP unconditionally.
REQ-025 RESP: MemRead/MemWrite low; winner's rvalid/done pulses; read data captured from mem_rdata into if_rdata or d_rdata.
REQ-026 RESP with a pending req -> ISSUE directly (arbitrated as in IDLE), else -> IDLE; sustained throughput one access per 2 cycles.
REQ-027 Latency: req sampled at edge E -> gnt in cycle E..E+1, rvalid/done in cycle E+1..E+2.
REQ-028 Arbitration RR_EN=1: single requester wins; both requesting -> port not granted last wins; last-grant pointer updates only on a grant.
REQ-029 Arbitration RR_EN=0: d_req always beats if_req.
REQ-030 Request dropped before grant is withdrawn without side effect; after gnt the requester may change addr/data freely.
REQ-031 Request held through its own RESP counts as a new request.
REQ-032 Strobes, gnt, rvalid, done are never high for both ports in the same cycle.

Reset
REQ-033 reset low: state IDLE, all outputs 0 (rdata registers 16'h0000), last-grant pointer = data port (fetch wins first tie), latched regs 0, asynchronously.
REQ-034 reset asserted mid-transaction: the transaction is discarded, no rvalid/done issued, and no MemWrite seen after reset.
REQ-035 First request accepted on the first rising edge with reset high.

Structure
REQ-036 Package mem_arb_pkg holds ADDR_W=8, DATA_W=16, state enum (IDLE, ISSUE, RESP), port index constants.
REQ-037 Sub-module rr_arb2: 2-request combinational picker with last-grant input, RR_EN parameter, one-hot grant output.
REQ-038 Memory outputs driven from registers/state decode only, no combinational path from req inputs.

Verification
REQ-039 Fetch read: memory preloaded 8'h04=16'h1234, if_req, if_addr=8'h04 -> if_gnt next cycle, if_rvalid one cycle later, if_rdata=16'h1234.
REQ-040 Store then load: d_we=1, d_addr=8'h20, d_wdata=16'hCAFE, then d_we=0 same address -> d_done twice, d_rdata=16'hCAFE, if_rdata unchanged.
REQ-041 Contention RR_EN=1: both ports hold req for 4 accesses -> grants alternate F,D,F,D, one access per 2 cycles.
REQ-042 Contention RR_EN=0: both req continuously -> data port granted every time, fetch granted only after d_req drops.
REQ-043 Reset in ISSUE of a store to 8'h30 -> outputs 0 immediately, no d_done, MemWrite never high after reset, state IDLE.
REQ-044 Withdraw: if_req pulsed one cycle while d transaction in RESP -> no if_gnt, no memory access for fetch.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and port indices for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester combinational picker: round-robin on last grant, or data-port fixed priority.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i[PORT_F] && req_i[PORT_D]) begin
      gnt_o = 2'b00;
      if (RR_EN && (last_i == PORT_D)) gnt_o[PORT_F] = 1'b1;
      else                             gnt_o[PORT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data port arbiter in front of a synchronous single-port memory.
// state | meaning: IDLE no access | ISSUE strobe + grant to winner | RESP read data back, pulse rvalid/done
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Memaddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [1:0]        req, pick;
  logic              is_issue, is_resp, is_d;

  assign req = {d_req, if_req};

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (|req) begin
          state_d = ISSUE;
          win_d   = pick[PORT_D];
          last_d  = pick[PORT_D];
          if (pick[PORT_D]) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      win_q      <= PORT_F;
      last_q     <= PORT_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata;
      d_rdata_q  <= d_rdata;
    end
  end

  assign is_issue = (state_q == ISSUE);
  assign is_resp  = (state_q == RESP);
  assign is_d     = (win_q == PORT_D);

  assign if_gnt    = is_issue && !is_d;
  assign d_gnt     = is_issue && is_d;
  assign MemRead   = is_issue && !(is_d && we_q);
  assign MemWrite  = is_issue && is_d && we_q;
  assign Memaddr   = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  // Read data is presented in the same cycle as its pulse, then held in the register.
  assign if_rvalid = is_resp && !is_d;
  assign d_done    = is_resp && is_d;
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = (d_done && !we_q) ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed table, contention/reset/withdraw sequences, random vs transaction model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [15:0] d_wdata;

  logic        if_gnt, if_rvalid, d_gnt, d_done, MemRead, MemWrite, busy;
  logic [15:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [7:0]  Memaddr;

  logic        if_gnt0, if_rvalid0, d_gnt0, d_done0, MemRead0, MemWrite0, busy0;
  logic [15:0] if_rdata0, d_rdata0, mem_wdata0, mem_rdata0;
  logic [7:0]  Memaddr0;

  logic [15:0] mem1 [256];
  logic [15:0] mem0 [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .Memaddr(Memaddr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.RR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt0), .d_done(d_done0), .d_rdata(d_rdata0),
    .MemRead(MemRead0), .MemWrite(MemWrite0), .Memaddr(Memaddr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  // Synchronous memories behind each arbiter
  always @(posedge clk) begin
    if (MemRead)  mem_rdata <= mem1[Memaddr];
    if (MemWrite) mem1[Memaddr] = mem_wdata;
    if (MemRead0)  mem_rdata0 <= mem0[Memaddr0];
    if (MemWrite0) mem0[Memaddr0] = mem_wdata0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model (RR_EN=1 instance) ----------------
  logic [15:0] m_mem [256];
  bit          model_en = 1'b0;
  bit          m_issue, m_port, m_last, m_we;
  logic [15:0] m_data;
  bit          e_gf, e_gd, e_rv, e_dn, e_rd, e_wr, e_busy;
  logic [7:0]  e_addr;
  logic [15:0] e_wdata, e_if, e_d;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_issue = 0; m_last = 1; m_port = 0; m_we = 0; m_data = 0;
      {e_gf, e_gd, e_rv, e_dn, e_rd, e_wr, e_busy} = '0;
      e_addr = 0; e_wdata = 0; e_if = 0; e_d = 0;
    end else begin
      bit in_issue;
      in_issue = m_issue;
      m_issue  = 0;
      {e_gf, e_gd, e_rv, e_dn, e_rd, e_wr, e_busy} = '0;
      if (in_issue) begin
        e_busy = 1;
        if (m_port) begin e_dn = 1; if (!m_we) e_d = m_data; end
        else begin e_rv = 1; e_if = m_data; end
      end else if (if_req || d_req) begin
        if (if_req && d_req) m_port = (m_last == 1) ? 1'b0 : 1'b1;
        else                 m_port = d_req;
        m_last = m_port; m_issue = 1; e_busy = 1;
        if (m_port) begin
          e_gd = 1; m_we = d_we; e_addr = d_addr;
          if (d_we) begin m_mem[d_addr] = d_wdata; e_wr = 1; e_wdata = d_wdata; end
          else begin m_data = m_mem[d_addr]; e_rd = 1; end
        end else begin
          e_gf = 1; m_we = 0; e_addr = if_addr; m_data = m_mem[if_addr]; e_rd = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      logic [63:0] act, exp;
      act = {1'b0, if_gnt, d_gnt, if_rvalid, d_done, MemRead, MemWrite, busy, if_rdata, d_rdata,
             (e_rd | e_wr) ? Memaddr : 8'h00, e_wr ? mem_wdata : 16'h0000};
      exp = {1'b0, e_gf, e_gd, e_rv, e_dn, e_rd, e_wr, e_busy, e_if, e_d,
             (e_rd | e_wr) ? e_addr : 8'h00, e_wr ? e_wdata : 16'h0000};
      check("random_vs_model", act, exp);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [63:0] all_outs();
    return {if_gnt, if_rvalid, d_gnt, d_done, MemRead, MemWrite, busy,
            if_rdata ^ d_rdata ^ mem_wdata, Memaddr, if_rdata | d_rdata | mem_wdata};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_if, exp_d;
    logic [15:0] orig30;
    bit          seen;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = {i[7:0], ~i[7:0]};
      mem0[i] = {i[7:0], ~i[7:0]};
    end
    mem1[8'h04] = 16'h1234;
    mem0[8'h04] = 16'h1234;

    tbl[0] = '{0, 0, 8'h04, 16'h0000, 16'h1234};
    tbl[1] = '{1, 1, 8'h20, 16'hCAFE, 16'h0000};
    tbl[2] = '{1, 0, 8'h20, 16'h0000, 16'hCAFE};
    tbl[3] = '{0, 0, 8'h20, 16'h0000, 16'hCAFE};
    tbl[4] = '{1, 1, 8'hFF, 16'h0001, 16'h0000};
    tbl[5] = '{1, 0, 8'hFF, 16'h0000, 16'h0001};
    tbl[6] = '{1, 0, 8'h00, 16'h0000, 16'h00FF};
    tbl[7] = '{0, 0, 8'h05, 16'h0000, 16'h05FA};

    reset = 0; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    #1 check("reset_outputs_zero", all_outs(), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1;

    exp_if = 0; exp_d = 0;
    for (int k = 0; k < 8; k++) begin
      if (tbl[k].is_d) begin
        d_req = 1; d_we = tbl[k].we; d_addr = tbl[k].addr; d_wdata = tbl[k].wdata;
      end else begin
        if_req = 1; if_addr = tbl[k].addr;
      end
      @(posedge clk); #1;
      check($sformatf("tbl%0d_gnt", k), {62'h0, d_gnt, if_gnt}, tbl[k].is_d ? 64'd2 : 64'd1);
      if_req = 0; d_req = 0; d_addr = 8'hAA; d_wdata = 16'h5555; if_addr = 8'h55;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_pulse", k), {62'h0, d_done, if_rvalid}, tbl[k].is_d ? 64'd2 : 64'd1);
      if (!tbl[k].is_d) exp_if = tbl[k].exp_rdata;
      else if (!tbl[k].we) exp_d = tbl[k].exp_rdata;
      check($sformatf("tbl%0d_rdata", k), {32'h0, if_rdata, d_rdata}, {32'h0, exp_if, exp_d});
      @(posedge clk); #1;
    end

    // Contention: RR instance alternates F,D; fixed-priority instance always D
    reset = 0; #2 reset = 1;
    @(posedge clk); #1;
    if_req = 1; if_addr = 8'h04; d_req = 1; d_we = 0; d_addr = 8'h20;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] e1, e0;
      @(posedge clk); #1;
      e1 = (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
      e0 = (k % 2 == 1) ? 2'b00 : 2'b10;
      check($sformatf("rr1_gnt_c%0d", k), {62'h0, d_gnt, if_gnt}, {62'h0, e1});
      check($sformatf("rr0_gnt_c%0d", k), {62'h0, d_gnt0, if_gnt0}, {62'h0, e0});
    end
    d_req = 0;
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk); #1;
      if (if_gnt0) seen = 1;
    end
    check("rr0_fetch_after_d_drop", {63'h0, seen}, 64'd1);
    if_req = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during ISSUE of a store
    orig30 = mem1[8'h30];
    d_req = 1; d_we = 1; d_addr = 8'h30; d_wdata = 16'hBEEF;
    @(posedge clk); #1;
    check("rst_store_issue", {62'h0, d_gnt, MemWrite}, 64'd3);
    d_req = 0; d_we = 0;
    #2 reset = 0;
    #1 check("rst_outputs_zero", all_outs(), 64'h0);
    @(posedge clk); #3 reset = 1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_done || MemWrite || busy) seen = 1;
    end
    check("rst_no_done_no_write", {63'h0, seen}, 64'd0);
    check("rst_mem30_unchanged", {48'h0, mem1[8'h30]}, {48'h0, orig30});

    // Withdrawn fetch request overlapping a data load
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 8'h20;
    @(posedge clk); #1;
    check("wd_d_gnt", {63'h0, d_gnt}, 64'd1);
    d_req = 0;
    @(negedge clk); if_req = 1; if_addr = 8'h77;
    @(posedge clk); #1;
    check("wd_d_done", {47'h0, d_done, d_rdata}, {47'h0, 1'b1, 16'hCAFE});
    @(negedge clk); if_req = 0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (if_gnt || if_rvalid || MemRead || MemWrite) seen = 1;
    end
    check("wd_no_fetch_access", {63'h0, seen}, 64'd0);

    // Randomized traffic against the transaction model
    reset = 0; #2 reset = 1;
    for (int i = 0; i < 256; i++) m_mem[i] = mem1[i];
    @(posedge clk); #1;
    model_en = 1;
    for (int c = 0; c < 600; c++) begin
      if (if_req && if_gnt) begin
        if ($urandom_range(3) == 0) if_addr = 8'($urandom_range(15));
        else if_req = 0;
      end else if (if_req && $urandom_range(15) == 0) begin
        if_req = 0;
      end else if (!if_req && $urandom_range(1) == 1) begin
        if_req = 1; if_addr = 8'($urandom_range(15));
      end
      if (d_req && d_gnt) begin
        if ($urandom_range(3) == 0) begin
          d_we = 1'($urandom_range(1)); d_addr = 8'($urandom_range(15)); d_wdata = 16'($urandom);
        end else d_req = 0;
      end else if (d_req && $urandom_range(15) == 0) begin
        d_req = 0;
      end else if (!d_req && $urandom_range(1) == 1) begin
        d_req = 1; d_we = 1'($urandom_range(1)); d_addr = 8'($urandom_range(15)); d_wdata = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    if_req = 0; d_req = 0;
    repeat (4) @(posedge clk);
    #1 model_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
